// File: rtl/poly_tone_gen.sv
// Polyphonic square-wave buzzer: per-key sync + debounce, programmable
// half-period dividers per channel, and a selectable mixer into one pin.
module poly_tone_gen #(
    parameter int NCH        = 8,
    parameter int DIV_W      = 24,
    parameter int DEB_CYCLES = 12000,
    parameter int DEB_W      = 16
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic [NCH-1:0]   SW,
    input  logic             CFG_WE,
    input  logic [3:0]       CFG_ADDR,
    input  logic [DIV_W-1:0] CFG_DATA,
    input  logic [1:0]       MODE,
    output logic             BZ,
    output logic [NCH-1:0]   ACTIVE
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // C5..C6 at 12 MHz; higher channels start disabled.
    function automatic logic [DIV_W-1:0] f_default(input int ch);
        logic [31:0] v;
        case (ch)
            0:       v = 32'd11472;
            1:       v = 32'd10221;
            2:       v = 32'd9104;
            3:       v = 32'd8595;
            4:       v = 32'd7653;
            5:       v = 32'd6818;
            6:       v = 32'd6072;
            7:       v = 32'd5730;
            default: v = 32'd0;
        endcase
        return v[DIV_W-1:0];
    endfunction

    logic [NCH-1:0]            r_sync1, r_sync2, r_stable;
    logic [NCH-1:0][DEB_W-1:0] r_deb_cnt;
    logic [NCH-1:0][DIV_W-1:0] r_half, r_cnt;
    logic [NCH-1:0]            r_wave;
    logic                      r_bz;
    logic [NCH-1:0]            r_active;

    logic [NCH-1:0] w_on, w_wr, w_gw;
    logic           w_mono, w_mix;

    always_comb begin
        w_mono = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            w_on[i] = !r_stable[i] && (r_half[i] != '0);
            // Addresses >= NCH never match, so out-of-range writes are dropped.
            w_wr[i] = CFG_WE && (CFG_ADDR == 4'(i));
            if (w_on[i])
                w_mono = r_wave[i];
        end
        w_gw = w_on & r_wave;
        case (MODE)
            2'd0:    w_mix = ^w_gw;
            2'd1:    w_mix = |w_gw;
            2'd2:    w_mix = w_mono;
            default: w_mix = 1'b0;
        endcase
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_stable  <= '1;
            r_deb_cnt <= '0;
            r_cnt     <= '0;
            r_wave    <= '0;
            r_bz      <= 1'b0;
            r_active  <= '0;
            for (int i = 0; i < NCH; i++)
                r_half[i] <= f_default(i);
        end else begin
            r_sync1  <= SW;
            r_sync2  <= r_sync1;
            r_bz     <= w_mix;
            r_active <= w_on;
            for (int i = 0; i < NCH; i++) begin
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_deb_cnt[i] == DEB_LAST) begin
                        r_stable[i]  <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end

                // A retune restarts phase so a shorter half can never be overrun.
                if (w_wr[i]) begin
                    r_half[i] <= CFG_DATA;
                    r_cnt[i]  <= '0;
                    r_wave[i] <= 1'b0;
                end else if (!w_on[i]) begin
                    r_cnt[i]  <= '0;
                    r_wave[i] <= 1'b0;
                end else if (r_cnt[i] == r_half[i] - 1'b1) begin
                    r_cnt[i]  <= '0;
                    r_wave[i] <= ~r_wave[i];
                end else begin
                    r_cnt[i]  <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign BZ     = r_bz;
    assign ACTIVE = r_active;

endmodule

// File: tb/tb_poly_tone_gen.sv
// Directed bench for poly_tone_gen (NCH=4, DIV_W=8, DEB_CYCLES=4); waves are
// predicted from the write/gate-on anchor cycle and the half-period.
module tb_poly_tone_gen;

    localparam int NCH   = 4;
    localparam int DIV_W = 8;

    logic             CLK_IN = 1'b0;
    logic             RST    = 1'b1;
    logic [NCH-1:0]   SW     = '1;
    logic             CFG_WE = 1'b0;
    logic [3:0]       CFG_ADDR = '0;
    logic [DIV_W-1:0] CFG_DATA = '0;
    logic [1:0]       MODE   = 2'd0;
    logic             BZ;
    logic [NCH-1:0]   ACTIVE;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    poly_tone_gen #(.NCH(NCH), .DIV_W(DIV_W), .DEB_CYCLES(4), .DEB_W(4)) dut (
        .CLK_IN(CLK_IN), .RST(RST), .SW(SW), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
        .CFG_DATA(CFG_DATA), .MODE(MODE), .BZ(BZ), .ACTIVE(ACTIVE)
    );

    always #5 CLK_IN = ~CLK_IN;

    typedef struct {
        logic [1:0] mode;
        int         h0;
        int         h1;
    } mix_vec_t;

    mix_vec_t mix_tab[6];

    task automatic tick();
        @(posedge CLK_IN);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cfg(input int addr, input int data);
        CFG_WE   = 1'b1;
        CFG_ADDR = 4'(addr);
        CFG_DATA = DIV_W'(data);
        tick();
        CFG_WE   = 1'b0;
    endtask

    // Wave level after edge n for a channel whose phase restarted at edge a.
    function automatic logic ew(input int n, input int a, input int h);
        if (n < a) return 1'b0;
        return (((n - a) / h) % 2) != 0;
    endfunction

    function automatic logic mixf(input logic [1:0] m, input logic w0, input logic w1);
        case (m)
            2'd0:    return w0 ^ w1;
            2'd1:    return w0 | w1;
            2'd2:    return w1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        int bad, c0, e0, a0, a1, a2;
        logic exp_act;

        mix_tab[0] = '{2'd0, 3, 5};
        mix_tab[1] = '{2'd1, 3, 5};
        mix_tab[2] = '{2'd2, 3, 5};
        mix_tab[3] = '{2'd3, 3, 5};
        mix_tab[4] = '{2'd0, 2, 7};
        mix_tab[5] = '{2'd1, 1, 4};

        ticks(3);
        chk("reset bz", 32'(BZ), 0);
        chk("reset active", 32'(ACTIVE), 0);
        RST = 1'b0;
        tick();

        // Single tone: gate latency and period
        cfg(0, 5);
        SW[0] = 1'b0;
        c0 = cyc;
        bad = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (ACTIVE[0] !== 1'b0) bad++;
        end
        chk("act0 early", 32'(bad), 0);
        tick();
        chk("act0 rise", 32'(ACTIVE[0]), 1);
        e0 = c0 + 6;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (BZ !== ew(cyc - 1, e0, 5)) bad++;
        end
        chk("tone half5", 32'(bad), 0);
        SW[0] = 1'b1;
        ticks(10);
        chk("act0 release", 32'(ACTIVE), 0);

        // Debounce: 3-cycle glitch rejected, 4-cycle pulse accepted
        SW[1] = 1'b0;
        ticks(3);
        SW[1] = 1'b1;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (ACTIVE[1] !== 1'b0) bad++;
        end
        chk("glitch3", 32'(bad), 0);
        c0 = cyc;
        SW[1] = 1'b0;
        ticks(4);
        SW[1] = 1'b1;
        bad = 0;
        for (int k = 5; k <= 14; k++) begin
            tick();
            exp_act = (cyc >= c0 + 7) && (cyc <= c0 + 10);
            if (ACTIVE[1] !== exp_act) bad++;
        end
        chk("pulse4 window", 32'(bad), 0);

        // Mixer modes with channels 0 and 1 held
        SW = 4'b1100;
        ticks(10);
        chk("mix active", 32'(ACTIVE), 32'h3);
        for (int r = 0; r < 6; r++) begin
            cfg(0, mix_tab[r].h0);
            a0 = cyc;
            cfg(1, mix_tab[r].h1);
            a1 = cyc;
            MODE = mix_tab[r].mode;
            bad = 0;
            for (int k = 0; k < 60; k++) begin
                tick();
                if (BZ !== mixf(mix_tab[r].mode, ew(cyc - 1, a0, mix_tab[r].h0),
                                ew(cyc - 1, a1, mix_tab[r].h1))) bad++;
            end
            chk($sformatf("mix row %0d", r), 32'(bad), 0);
        end

        // Retune ch2 mid-period (half 9, cnt 7, wave high) to half 4
        SW = 4'b1011;
        MODE = 2'd0;
        ticks(10);
        chk("ch2 active", 32'(ACTIVE), 32'h4);
        cfg(2, 9);
        a2 = cyc;
        ticks(16);
        chk("pre-retune bz", 32'(BZ), 1);
        cfg(2, 4);
        a2 = cyc;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            CFG_WE   = (k == 8) || (k == 12);
            CFG_ADDR = (k == 8) ? 4'd5 : 4'd6;
            CFG_DATA = '0;
            tick();
            if (BZ !== ew(cyc - 1, a2, 4)) bad++;
            if (ACTIVE !== 4'b0100) bad++;
        end
        CFG_WE = 1'b0;
        chk("retune + addr>=NCH", 32'(bad), 0);

        // Zero divider silences a pressed channel
        SW = 4'b0011;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            CFG_WE   = (k == 8);
            CFG_ADDR = 4'd3;
            CFG_DATA = '0;
            if (k == 10) MODE = 2'd2;
            tick();
            if (k == 7) chk("ch3 active", 32'(ACTIVE[3]), 1);
            if (k >= 9 && ACTIVE[3] !== 1'b0) bad++;
            if (BZ !== ew(cyc - 1, a2, 4)) bad++;
        end
        CFG_WE = 1'b0;
        chk("ch3 half0", 32'(bad), 0);

        // Asynchronous reset mid-note
        while (!ew(cyc - 1, a2, 4)) tick();
        chk("bz before reset", 32'(BZ), 1);
        #3 RST = 1'b1;
        #1;
        chk("async rst bz", 32'(BZ), 0);
        chk("async rst active", 32'(ACTIVE), 0);
        SW = '1;
        MODE = 2'd0;
        tick();
        RST = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (BZ !== 1'b0 || ACTIVE !== '0) bad++;
        end
        chk("idle after reset", 32'(bad), 0);

        // Default divider table restored: ch0 half = 11472 mod 256 = 208
        SW[0] = 1'b0;
        c0 = cyc;
        e0 = c0 + 6;
        bad = 0;
        for (int k = 0; k < 221; k++) begin
            tick();
            if (BZ !== ew(cyc - 1, e0, 208)) bad++;
        end
        chk("default half0", 32'(bad), 0);
        chk("default rise", 32'(BZ), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
